// File: rtl/rom_section_decoder_pkg.sv
// Shared types and the default GnW download layout for the ioctl section decoder.
package rom_section_decoder_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LEN,
        S_DATA,
        S_DONE,
        S_ERR
    } state_t;

    typedef logic [31:0] len_t;

    // GnW layout: conf (1-byte prefix), image (4-byte prefix), palette 768, rom 4096
    localparam int                GNW_NUM_SEC   = 4;
    localparam logic [3*4-1:0]    GNW_LEN_BYTES = {3'd0, 3'd0, 3'd4, 3'd1};
    localparam logic [32*4-1:0]   GNW_FIXED_LEN = {32'd4096, 32'd768, 32'd0, 32'd0};
    localparam len_t              GNW_MAX_LEN   = 32'h0100_0000;

endpackage

// File: rtl/rom_len_shifter.sv
// Big-endian length accumulator for 1..4 prefix bytes; last_o flags that the
// next shifted byte completes the length, len_o is the value including it.
module rom_len_shifter
    import rom_section_decoder_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       load_i,
    input  logic [2:0] nbytes_i,
    input  logic       shift_i,
    input  logic [7:0] byte_i,
    output len_t       len_o,
    output logic       last_o
);

    len_t       acc_q;
    logic [2:0] rem_q;

    assign len_o  = {acc_q[23:0], byte_i};
    assign last_o = (rem_q == 3'd1);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc_q <= '0;
            rem_q <= '0;
        end else if (load_i) begin
            acc_q <= '0;
            rem_q <= nbytes_i;
        end else if (shift_i) begin
            acc_q <= len_o;
            rem_q <= rem_q - 3'd1;
        end
    end

endmodule

// File: rtl/rom_section_decoder.sv
// Parses the MiSTer ioctl download stream into a header byte followed by
// NUM_SEC length-prefixed or fixed-length sections with per-byte write strobes.
module rom_section_decoder
    import rom_section_decoder_pkg::*;
#(
    parameter int                    AW        = 25,
    parameter int                    NUM_SEC   = GNW_NUM_SEC,
    parameter logic [3*NUM_SEC-1:0]  LEN_BYTES = GNW_LEN_BYTES,
    parameter logic [32*NUM_SEC-1:0] FIXED_LEN = GNW_FIXED_LEN,
    parameter logic [31:0]           MAX_LEN   = GNW_MAX_LEN
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  ioctl_download,
    input  logic                  ioctl_wr,
    input  logic [AW-1:0]         ioctl_addr,
    input  logic [7:0]            ioctl_dout,
    output logic [7:0]            mcuid,
    output logic [NUM_SEC-1:0]    sec_active,
    output logic                  sec_wr,
    output logic [7:0]            sec_data,
    output logic [31:0]           sec_offset,
    output logic [NUM_SEC*AW-1:0] sec_base,
    output logic                  done,
    output logic                  err
);

    localparam int SECW = (NUM_SEC > 1) ? $clog2(NUM_SEC) : 1;

    state_t                state_q, state_d, cur_state;
    logic [SECW-1:0]       sec_q, sec_d;
    len_t                  len_q, len_d;
    len_t                  count_q, count_d;
    logic                  dl_q, start, fall;
    logic                  last_q, last_d;
    logic [7:0]            mcuid_q, mcuid_d;
    logic [NUM_SEC-1:0]    sec_active_q, sec_active_d;
    logic                  sec_wr_q, sec_wr_d;
    logic [7:0]            sec_data_q, sec_data_d;
    len_t                  sec_offset_q, sec_offset_d;
    logic [NUM_SEC*AW-1:0] sec_base_q, sec_base_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  sh_load, sh_shift, sh_last;
    len_t                  sh_len;
    logic                  do_enter;

    logic [2:0]            lb_arr [NUM_SEC];
    len_t                  fl_arr [NUM_SEC];

    logic [SECW:0]         enter_from;
    logic                  ent_found, ent_prefix;
    logic [SECW-1:0]       ent_sec;
    logic [2:0]            ent_nbytes;
    len_t                  ent_len;

    for (genvar k = 0; k < NUM_SEC; k++) begin : g_fields
        assign lb_arr[k] = LEN_BYTES[3*k +: 3];
        assign fl_arr[k] = FIXED_LEN[32*k +: 32];
    end

    assign start     = ioctl_download & ~dl_q;
    assign fall      = ~ioctl_download & dl_q;
    assign cur_state = start ? S_HDR : state_q;
    assign enter_from = (cur_state == S_HDR) ? '0
                                             : (SECW+1)'(sec_q) + (SECW+1)'(1);

    // First section at or after enter_from that is not a zero-length fixed
    // section; a run of empty sections is thus skipped within a single byte.
    always_comb begin
        ent_found  = 1'b0;
        ent_prefix = 1'b0;
        ent_sec    = '0;
        ent_nbytes = '0;
        ent_len    = '0;
        for (int k = 0; k < NUM_SEC; k++) begin
            if (!ent_found && k >= int'(enter_from) &&
                (lb_arr[k] != 3'd0 || fl_arr[k] != 32'd0)) begin
                ent_found  = 1'b1;
                ent_prefix = (lb_arr[k] != 3'd0);
                ent_sec    = SECW'(k);
                ent_nbytes = lb_arr[k];
                ent_len    = fl_arr[k];
            end
        end
    end

    rom_len_shifter u_len_shifter (
        .clk_i    (clk_sys),
        .reset_i  (reset),
        .load_i   (sh_load),
        .nbytes_i (ent_nbytes),
        .shift_i  (sh_shift),
        .byte_i   (ioctl_dout),
        .len_o    (sh_len),
        .last_o   (sh_last)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        sec_d        = sec_q;
        len_d        = len_q;
        count_d      = count_q;
        mcuid_d      = mcuid_q;
        sec_wr_d     = 1'b0;
        sec_data_d   = sec_data_q;
        sec_offset_d = sec_offset_q;
        sec_active_d = sec_active_q;
        sec_base_d   = sec_base_q;
        last_d       = 1'b0;
        sh_load      = 1'b0;
        sh_shift     = 1'b0;
        do_enter     = 1'b0;

        if (last_q) sec_active_d = '0;
        if (start) begin
            state_d      = S_HDR;
            sec_active_d = '0;
            sec_base_d   = '0;
        end

        if (ioctl_wr) begin
            unique case (cur_state)
                S_HDR: begin
                    mcuid_d  = ioctl_dout;
                    do_enter = 1'b1;
                end
                S_LEN: begin
                    sh_shift = 1'b1;
                    if (sh_last) begin
                        if (sh_len > MAX_LEN) begin
                            state_d = S_ERR;
                        end else if (sh_len == 32'd0) begin
                            do_enter = 1'b1;
                        end else begin
                            len_d   = sh_len;
                            count_d = '0;
                            state_d = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    sec_wr_d            = 1'b1;
                    sec_data_d          = ioctl_dout;
                    sec_offset_d        = count_q;
                    sec_active_d        = '0;
                    sec_active_d[sec_q] = 1'b1;
                    if (count_q == 32'd0) sec_base_d[int'(sec_q)*AW +: AW] = ioctl_addr;
                    if (count_q == len_q - 32'd1) begin
                        last_d   = 1'b1;
                        do_enter = 1'b1;
                    end else begin
                        count_d = count_q + 32'd1;
                    end
                end
                default: ;
            endcase
        end

        if (do_enter) begin
            count_d = '0;
            if (!ent_found) begin
                state_d = S_DONE;
            end else begin
                sec_d = ent_sec;
                if (ent_prefix) begin
                    state_d = S_LEN;
                    sh_load = 1'b1;
                end else begin
                    state_d = S_DATA;
                    len_d   = ent_len;
                end
            end
        end

        // A byte on the falling cycle is consumed above before the abort applies.
        if (fall && !(state_d inside {S_IDLE, S_DONE, S_ERR})) state_d = S_ERR;
        if (state_d == S_ERR) sec_active_d = '0;

        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_ERR);
    end

    always_ff @(posedge clk_sys) begin
        // NOTE: sampled even during reset so a download already in progress is not mistaken for a new start.
        dl_q <= ioctl_download;
        if (reset) begin
            state_q      <= S_IDLE;
            sec_q        <= '0;
            len_q        <= '0;
            count_q      <= '0;
            last_q       <= 1'b0;
            mcuid_q      <= '0;
            sec_active_q <= '0;
            sec_wr_q     <= 1'b0;
            sec_data_q   <= '0;
            sec_offset_q <= '0;
            sec_base_q   <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of its peers.
            state_q      <= state_d;
            sec_q        <= sec_d;
            len_q        <= len_d;
            count_q      <= count_d;
            last_q       <= last_d;
            mcuid_q      <= mcuid_d;
            sec_active_q <= sec_active_d;
            sec_wr_q     <= sec_wr_d;
            sec_data_q   <= sec_data_d;
            sec_offset_q <= sec_offset_d;
            sec_base_q   <= sec_base_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign mcuid      = mcuid_q;
    assign sec_active = sec_active_q;
    assign sec_wr     = sec_wr_q;
    assign sec_data   = sec_data_q;
    assign sec_offset = sec_offset_q;
    assign sec_base   = sec_base_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_rom_section_decoder.sv
// Randomised bench for rom_section_decoder: streams are parsed by a whole-stream
// reference model into expected writes, bases and final status.
module tb_rom_section_decoder;

    localparam int AW = 25;
    localparam int NS = 4;
    localparam longint MAXL = 64'h0100_0000;

    typedef struct {
        int         sec;
        int         off;
        logic [7:0] data;
        bit         last;
    } wr_t;

    logic                 clk_sys = 1'b0;
    logic                 reset;
    logic                 ioctl_download;
    logic                 ioctl_wr;
    logic [AW-1:0]        ioctl_addr;
    logic [7:0]           ioctl_dout;
    logic [7:0]           mcuid;
    logic [NS-1:0]        sec_active;
    logic                 sec_wr;
    logic [7:0]           sec_data;
    logic [31:0]          sec_offset;
    logic [NS*AW-1:0]     sec_base;
    logic                 done;
    logic                 err;

    int         lb_tab [NS] = '{1, 4, 0, 0};
    int         fl_tab [NS] = '{0, 0, 768, 4096};
    logic [7:0] stim [$];
    wr_t        exp_q [$];
    wr_t        mon_e;
    logic [AW-1:0] exp_base [NS];
    logic       exp_done, exp_err;
    logic [7:0] exp_mcuid;
    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_wr     = 0;
    bit         prev_last = 0;

    rom_section_decoder dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .mcuid          (mcuid),
        .sec_active     (sec_active),
        .sec_wr         (sec_wr),
        .sec_data       (sec_data),
        .sec_offset     (sec_offset),
        .sec_base       (sec_base),
        .done           (done),
        .err            (err)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Stream layout: id, conf length byte, conf data, 4-byte image length, tail bytes.
    function automatic void build(input logic [7:0] id, input logic [7:0] conf_len,
                                  input logic [31:0] img_len, input int tail);
        stim.delete();
        stim.push_back(id);
        stim.push_back(conf_len);
        for (int i = 0; i < int'(conf_len); i++) stim.push_back(8'($urandom));
        for (int i = 3; i >= 0; i--) stim.push_back(img_len[8*i +: 8]);
        for (int i = 0; i < tail; i++) stim.push_back(8'($urandom));
    endfunction

    // Parses the first n stream bytes; download is assumed to drop afterwards.
    function automatic void model(input int n);
        int     p;
        longint len;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        for (int s = 0; s < NS; s++) exp_base[s] = '0;
        if (n == 0) begin
            exp_err = 1'b1;
            return;
        end
        exp_mcuid = stim[0];
        p = 1;
        for (int s = 0; s < NS; s++) begin
            if (lb_tab[s] != 0) begin
                if (p + lb_tab[s] > n) begin
                    exp_err = 1'b1;
                    return;
                end
                len = 0;
                for (int i = 0; i < lb_tab[s]; i++) begin
                    len = len * 256 + longint'(stim[p]);
                    p++;
                end
                if (len > MAXL) begin
                    exp_err = 1'b1;
                    return;
                end
            end else begin
                len = longint'(fl_tab[s]);
            end
            for (longint o = 0; o < len; o++) begin
                if (p >= n) begin
                    exp_err = 1'b1;
                    return;
                end
                exp_q.push_back('{sec: s, off: int'(o), data: stim[p], last: (o == len - 1)});
                if (o == 0) exp_base[s] = AW'(p);
                p++;
            end
        end
        exp_done = 1'b1;
    endfunction

    task automatic send(input int from, input int to, input bit raise_first);
        for (int i = from; i < to; i++) begin
            @(negedge clk_sys);
            if (raise_first && i == from) ioctl_download = 1'b1;
            ioctl_wr   = 1'b1;
            ioctl_addr = AW'(i);
            ioctl_dout = stim[i];
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk_sys);
                ioctl_wr = 1'b0;
            end
        end
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
    endtask

    task automatic start_dl();
        @(negedge clk_sys);
        ioctl_download = 1'b1;
    endtask

    task automatic end_dl();
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        repeat (3) @(negedge clk_sys);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_mcuid"}, mcuid, exp_mcuid);
        check({tag, "_done"}, done, exp_done);
        check({tag, "_err"}, err, exp_err);
        check({tag, "_active"}, sec_active, 0);
        check({tag, "_pending"}, exp_q.size(), 0);
        for (int s = 0; s < NS; s++) check({tag, "_base"}, sec_base[s*AW +: AW], exp_base[s]);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_mcuid"}, mcuid, 0);
        check({tag, "_active"}, sec_active, 0);
        check({tag, "_wr"}, sec_wr, 0);
        check({tag, "_data"}, sec_data, 0);
        check({tag, "_offset"}, sec_offset, 0);
        check({tag, "_base"}, sec_base, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    always @(negedge clk_sys) begin
        check("active_onehot", ($countones(sec_active) <= 1), 1'b1);
        if (sec_wr) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                check("unexpected_wr", sec_wr, 1'b0);
                prev_last = 1'b0;
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_data", sec_data, mon_e.data);
                check("wr_offset", sec_offset, mon_e.off);
                check("wr_active", sec_active, 1 << mon_e.sec);
                prev_last = mon_e.last;
            end
        end else begin
            if (prev_last) check("active_clear", sec_active, 0);
            prev_last = 1'b0;
        end
    end

    initial begin
        repeat (90000) @(posedge clk_sys);
        $display("FAIL watchdog: bench did not reach its end within the cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int conf_n, img_n, part;
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        repeat (3) @(negedge clk_sys);
        check_zero("reset");
        reset = 1'b0;
        @(negedge clk_sys);

        // 1: nominal GnW stream
        build(8'h2A, 8'd2, 32'd3, 3 + fl_tab[2] + fl_tab[3]);
        model(stim.size());
        n_wr = 0;
        start_dl();
        send(0, stim.size(), 1'b0);
        end_dl();
        check_status("t1");
        check("t1_nwr", n_wr, 2 + 3 + 768 + 4096);

        // 2: empty conf section, header byte on the same cycle as the download edge
        img_n = $urandom_range(1, 8);
        build(8'($urandom), 8'd0, 32'(img_n), img_n + fl_tab[2] + fl_tab[3]);
        model(stim.size());
        send(0, stim.size(), 1'b1);
        end_dl();
        check_status("t2");

        // 3: image length above MAX_LEN, trailing bytes ignored
        build(8'($urandom), 8'd1, 32'h0200_0000, 20);
        model(stim.size());
        start_dl();
        send(0, stim.size(), 1'b0);
        end_dl();
        check_status("t3");

        // 4: download drops after 100 palette bytes
        build(8'($urandom), 8'd2, 32'd3, 3 + fl_tab[2] + fl_tab[3]);
        model(2 + 2 + 4 + 3 + 100);
        start_dl();
        send(0, 2 + 2 + 4 + 3 + 100, 1'b0);
        end_dl();
        check_status("t4");

        // 5: restart while in the rom section, then a full stream
        conf_n = $urandom_range(1, 8);
        img_n  = $urandom_range(1, 16);
        build(8'($urandom), 8'(conf_n), 32'(img_n), img_n + fl_tab[2] + fl_tab[3]);
        part = 2 + conf_n + 4 + img_n + fl_tab[2] + 200;
        model(part);
        start_dl();
        send(0, part, 1'b0);
        repeat (2) @(negedge clk_sys);
        check("t5_pending", exp_q.size(), 0);
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        check("t5_base_clr", sec_base, 0);
        check("t5_err_clr", err, 0);
        check("t5_done_clr", done, 0);
        conf_n = $urandom_range(1, 8);
        img_n  = $urandom_range(1, 16);
        build(8'($urandom), 8'(conf_n), 32'(img_n), img_n + fl_tab[2] + fl_tab[3]);
        model(stim.size());
        send(0, stim.size(), 1'b0);
        end_dl();
        check_status("t5");

        // 6: one-cycle reset mid-image, bytes ignored until the next download edge
        build(8'($urandom), 8'd2, 32'd50, 50 + fl_tab[2] + fl_tab[3]);
        model(2 + 2 + 4 + 20);
        start_dl();
        send(0, 2 + 2 + 4 + 20, 1'b0);
        @(negedge clk_sys);
        check("t6_pending", exp_q.size(), 0);
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        check_zero("t6_rst");
        send(28, 60, 1'b0);
        end_dl();
        check("t6_err_idle", err, 0);
        check("t6_done_idle", done, 0);
        check("t6_mcuid_idle", mcuid, 0);
        build(8'($urandom), 8'd3, 32'd5, 5 + fl_tab[2] + fl_tab[3]);
        model(stim.size());
        start_dl();
        send(0, stim.size(), 1'b0);
        end_dl();
        check_status("t6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
